// File: rtl/aes_frame_pkg.sv
// Shared constants and types for the AES frame transmitter.
package aes_frame_pkg;

    // Width of one FIFO word: 2-bit tag + 32-bit payload
    localparam int FIFO_W = 34;

    // FIFO word tags, bits [33:32]
    localparam logic [1:0] TAG_DATA = 2'b00;
    localparam logic [1:0] TAG_HDR  = 2'b01;
    localparam logic [1:0] TAG_KEY  = 2'b10;
    localparam logic [1:0] TAG_LAST = 2'b11;

    // Key-mode codes
    localparam logic [1:0] KM_128     = 2'd0;
    localparam logic [1:0] KM_192     = 2'd1;
    localparam logic [1:0] KM_256     = 2'd2;
    localparam logic [1:0] KM_ILLEGAL = 2'd3;

    // Number of 32-bit key words per key mode, and words per data block
    localparam logic [3:0] KEY_WORDS_128 = 4'd4;
    localparam logic [3:0] KEY_WORDS_192 = 4'd6;
    localparam logic [3:0] KEY_WORDS_256 = 4'd8;
    localparam logic [3:0] BLK_WORDS     = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        KEY,
        WAIT_BLK,
        DATA
    } state_t;

    // Key word count for a key mode; the illegal code never reaches the serializer
    function automatic logic [3:0] key_words(input logic [1:0] key_mode);
        case (key_mode)
            KM_192:  key_words = KEY_WORDS_192;
            KM_256:  key_words = KEY_WORDS_256;
            default: key_words = KEY_WORDS_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_word_ser.sv
// 256-bit load/shift register emitting 32-bit words MSW first.
// Shared by the key and data phases of the frame transmitter.
module aes_word_ser (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [255:0] i_load_data,
    input  logic [3:0]   i_load_words,
    input  logic         i_shift,
    output logic [31:0]  o_word,
    output logic         o_last
);

    logic [255:0] r_shreg;
    logic [3:0]   r_cnt;    // words remaining after the one currently presented

    // Load a new payload, or advance one word per accepted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_load_data;
            r_cnt   <= i_load_words - 4'd1;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[223:0], 32'h0};
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Current word is always the top slice of the register
    always_comb begin
        o_word = r_shreg[255:224];
        o_last = (r_cnt == 4'd0);
    end

endmodule

// File: rtl/aes_frame_tx.sv
// Frames an AES command (header, key, data blocks) into tagged FIFO words.
module aes_frame_tx #(
    parameter int FIFO_W = 34,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_mode,
    input  logic [1:0]        i_cmd_key_mode,
    input  logic [255:0]      i_cmd_key,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_blk_valid,
    output logic              o_blk_ready,
    input  logic [127:0]      i_blk_data,
    output logic              o_wr_fifo,
    output logic [FIFO_W-1:0] o_data_fifo,
    input  logic              i_full_fifo,
    output logic              o_busy,
    output logic              o_err
);

    import aes_frame_pkg::*;

    localparam int WORD_W = aes_frame_pkg::FIFO_W;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_mode;
    logic [1:0]         r_key_mode;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_blk_cnt;
    logic               r_err;

    logic               w_cmd_acc;
    logic               w_cmd_bad;
    logic               w_blk_acc;
    logic               w_ser_load;
    logic [255:0]       w_ser_data;
    logic [3:0]         w_ser_words;
    logic               w_ser_shift;
    logic [31:0]        w_ser_word;
    logic               w_ser_last;
    logic [WORD_W-1:0]  w_word;

    assign w_cmd_acc   = i_cmd_valid & o_cmd_ready;
    assign w_cmd_bad   = (i_cmd_len == '0) | (i_cmd_key_mode == KM_ILLEGAL);
    assign w_blk_acc   = i_blk_valid & o_blk_ready;
    // Key is preloaded at command accept so it is ready once the header is out
    assign w_ser_load  = (w_cmd_acc & ~w_cmd_bad) | w_blk_acc;
    assign w_ser_data  = w_blk_acc ? {i_blk_data, 128'h0} : i_cmd_key;
    assign w_ser_words = w_blk_acc ? BLK_WORDS : key_words(i_cmd_key_mode);
    assign w_ser_shift = o_wr_fifo & ((r_state == KEY) | (r_state == DATA));

    aes_word_ser u_ser (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_ser_load),
        .i_load_data  (w_ser_data),
        .i_load_words (w_ser_words),
        .i_shift      (w_ser_shift),
        .o_word       (w_ser_word),
        .o_last       (w_ser_last)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; every word-producing state advances only on a write
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_cmd_acc && !w_cmd_bad) w_state_next = HDR;
            HDR:      if (!i_full_fifo) w_state_next = KEY;
            KEY:      if (!i_full_fifo && w_ser_last) w_state_next = WAIT_BLK;
            WAIT_BLK: if (i_blk_valid) w_state_next = DATA;
            DATA: begin
                if (!i_full_fifo && w_ser_last) begin
                    w_state_next = (r_blk_cnt != '0) ? WAIT_BLK : IDLE;
                end
            end
            default:  w_state_next = IDLE;
        endcase
    end

    // FSM outputs; the FIFO word is a mux of registered values only
    always_comb begin
        o_cmd_ready = (r_state == IDLE);
        o_blk_ready = (r_state == WAIT_BLK);
        o_busy      = (r_state != IDLE);
        o_wr_fifo   = ((r_state == HDR) || (r_state == KEY) || (r_state == DATA)) && !i_full_fifo;
        o_err       = r_err;
        case (r_state)
            HDR:     w_word = {TAG_HDR, r_mode, r_key_mode, 13'h0, 16'(r_len)};
            KEY:     w_word = {TAG_KEY, w_ser_word};
            // Block counter already decremented at accept: zero means final block
            DATA:    w_word = {(w_ser_last && r_blk_cnt == '0) ? TAG_LAST : TAG_DATA, w_ser_word};
            default: w_word = '0;
        endcase
        o_data_fifo = FIFO_W'(w_word);
    end

    // Command capture, block counter and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_key_mode <= 2'd0;
            r_len      <= '0;
            r_blk_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_cmd_acc & w_cmd_bad;
            if (w_cmd_acc) begin
                r_mode     <= i_cmd_mode;
                r_key_mode <= i_cmd_key_mode;
                r_len      <= i_cmd_len;
                r_blk_cnt  <= i_cmd_len;
            end else if (w_blk_acc) begin
                r_blk_cnt  <= r_blk_cnt - 1'b1;
            end
        end
    end

endmodule

// File: doc/aes_frame_tx.md
AES_FRAME_TX -- requirements
Module: aes_frame_tx

Interface
REQ-001 SHALL have parameters: FIFO_W, default 34, FIFO word width; LEN_W, default 16, block-count width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command accepted when both are high.
- i_cmd_mode  in  1  1 = encrypt, 0 = decrypt.
- i_cmd_key_mode  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal.
- i_cmd_key  in  256  key, left-justified: a 128-bit key sits in [255:128].
- i_cmd_len  in  LEN_W  number of 128-bit blocks.
- i_blk_valid  in  1  block offered.
- o_blk_ready  out  1  block accepted when both are high.
- i_blk_data  in  128  plaintext or ciphertext block.
- o_wr_fifo  out  1  write strobe to the AES input FIFO.
- o_data_fifo  out  FIFO_W  FIFO word.
- i_full_fifo  in  1  FIFO full.
- o_busy  out  1  frame in progress.
- o_err  out  1  one-cycle pulse on a rejected command.

Function
REQ-003 FIFO word format SHALL be [33:32] tag plus [31:0] payload. Tags: 01 header, 10 key, 00 data, 11 last data word of the frame.
REQ-004 Header payload SHALL be [31] mode, [30:29] key_mode, [28:16] zero, [15:0] len.
REQ-005 Key words SHALL be emitted most-significant word first: 4 words for AES-128, 6 for AES-192, 8 for AES-256.
REQ-006 Each block SHALL be emitted as 4 data words, most-significant word first.
REQ-007 The final word of the final block SHALL carry tag 11. All other data words SHALL carry tag 00.
REQ-008 FSM states SHALL be IDLE, HDR, KEY, WAIT_BLK, DATA.
REQ-009 o_cmd_ready SHALL be high only in IDLE. o_blk_ready SHALL be high only in WAIT_BLK.
REQ-010 Command acceptance in cycle N SHALL capture the mode, key mode, key and len fields. It SHALL also move to HDR, so the header is written no earlier than cycle N+1.
REQ-011 o_wr_fifo SHALL equal (state is HDR, KEY or DATA) AND NOT i_full_fifo. o_data_fifo SHALL be driven from registers and SHALL be stable while a write is stalled.
REQ-012 Each write SHALL advance exactly one word. While i_full_fifo is high, no word SHALL be lost, duplicated or reordered.
REQ-013 Transitions:
- HDR goes to KEY after the header write.
- KEY goes to WAIT_BLK after the last key word.
- WAIT_BLK goes to DATA on block acceptance; the block is registered.
- DATA goes to WAIT_BLK after its 4th word if blocks remain, otherwise to IDLE.
REQ-014 The block counter SHALL be LEN_W bits. It SHALL load len at command acceptance and decrement once per block accepted.
REQ-015 len = 65535 SHALL be supported without wrap.
REQ-016 A command with len = 0 or key_mode = 3 SHALL be accepted. It SHALL pulse o_err in cycle N+1, write no words, and leave the FSM in IDLE.
REQ-017 o_busy SHALL be high in every state except IDLE.
REQ-018 An i_blk_valid asserted outside WAIT_BLK SHALL be ignored until WAIT_BLK is reached.

Reset
REQ-019 While rst is high, all of the following SHALL hold:
- FSM is in IDLE and the counters are zero.
- o_wr_fifo, o_err and o_busy are 0, and o_data_fifo is 0.
- o_cmd_ready is 1 and o_blk_ready is 0.
REQ-020 Reset mid-frame SHALL abort the frame immediately. No further words SHALL be written, and the partial frame is not terminated.

Structure
REQ-021 Package aes_frame_pkg SHALL hold: the tag constants, the key-mode codes, the key word counts (4/6/8), the FSM state typedef and FIFO_W.
REQ-022 One sub-module, aes_word_ser, SHALL perform the shift-out. It is a 256-bit load/shift register with a word counter and a last-word flag, shared by the KEY and DATA phases.

Verification
REQ-023 Bench scenarios:
- AES-128, mode 1, len 1, key 000102..0F, block 00112233..EEFF, FIFO never full -> 9 words in consecutive cycles. Header = tag 01, payload 0x80000001. Then 4 key words starting 0x00010203. Then data 0x00112233, 0x44556677, 0x8899AABB, and finally 0xCCDDEEFF with tag 11.
- AES-256, len 3, with i_full_fifo toggled every other cycle -> exactly 1 + 8 + 12 words, in order, with o_data_fifo stable during stalls.
- len = 0 -> o_err high for exactly 1 cycle, zero writes, o_busy stays 0.
- key_mode = 3 -> o_err high for exactly 1 cycle, zero writes.
- AES-192, len 2, rst asserted after the 3rd data word -> o_wr_fifo is 0 in the same cycle. After reset, a new len-1 frame emits a correct 11-word sequence.
- i_blk_valid held high from the start of the command -> the first block is accepted only after the 6th key word. Total block accepts equal len.
